// File: rtl/nids_hdr_parser_if.sv
// Byte-stream handshake into the NIDS header parser.
// master drives data/valid/sof/eof; slave returns in_ready.
interface nids_hdr_parser_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_eof;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_sof,
    output in_eof,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sof,
    input  in_eof,
    output in_ready
  );
endinterface

// File: rtl/nids_hdr_parser.sv
// IPv4/TCP header field extractor feeding the decision-tree forest.
// Ports: clk, rst (async low), s (byte stream), done/start
// handshake to the trees, registered header fields, error
// pulses and saturating packet/error counters.
module nids_hdr_parser #(
  parameter int CNT_W        = 16,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  nids_hdr_parser_if.slave  s,
  input  logic              done,
  output logic              start,
  output logic [15:0]       l3_iph_tot_len,
  output logic [3:0]        l3_iph_ihl,
  output logic [7:0]        l3_iph_tos,
  output logic [12:0]       l3_iph_frag_off,
  output logic [15:0]       l3_iph_id,
  output logic              l3_iph_df,
  output logic [15:0]       l4_tcph_window,
  output logic              l4_tcph_syn,
  output logic              l4_tcph_fin,
  output logic              l4_tcph_rst,
  output logic              l4_tcph_ack,
  output logic [3:0]        l4_tcph_doff,
  output logic              non_tcp,
  output logic              err_trunc,
  output logic              timeout,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IP_HDR,
    S_IP_OPT,
    S_TCP_HDR,
    S_DRAIN,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [15:0] tot_len;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [12:0] frag_off;
    logic [15:0] id;
    logic        df;
    logic [15:0] window;
    logic        syn;
    logic        fin;
    logic        tcp_rst;
    logic        ack;
    logic [3:0]  doff;
  } hdr_t;

  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [3:0] ver_q, ver_d;
  logic       skip_q, skip_d;
  hdr_t       sh_q, sh_d;
  hdr_t       fld_q;
  logic       start_q, start_d;
  logic       ntcp_q, ntcp_d;
  logic       trunc_q, trunc_d;
  logic       tmo_q, tmo_d;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

  logic       xfer;
  logic       restart;
  logic [7:0] din;
  logic [5:0] opt_last;
  logic       err_ev;

  assign s.in_ready = (state_q != S_ISSUE) && (state_q != S_WAIT);
  assign xfer       = s.in_valid && s.in_ready;
  assign din        = s.in_data;
  // Option bytes are (ihl-5)*4; counter runs 0..len-1.
  assign opt_last   = {sh_q.ihl, 2'b00} - 6'd21;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    ver_d   = ver_q;
    skip_d  = skip_q;
    sh_d    = sh_q;
    ntcp_d  = 1'b0;
    trunc_d = 1'b0;
    tmo_d   = 1'b0;
    restart = 1'b0;

    // A new sof mid-packet aborts the old one and
    // is itself byte 0 of the next packet.
    if (xfer && s.in_sof && state_q != S_IDLE) begin
      if (skip_q) ntcp_d  = 1'b1;
      else        trunc_d = 1'b1;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (xfer && s.in_sof) begin
            if (s.in_eof) trunc_d = 1'b1;
            else          restart = 1'b1;
          end
        end
        S_IP_HDR: begin
          if (xfer) begin
            cnt_d = cnt_q + 6'd1;
            case (cnt_q)
              6'd1: sh_d.tos           = din;
              6'd2: sh_d.tot_len[15:8] = din;
              6'd3: sh_d.tot_len[7:0]  = din;
              6'd4: sh_d.id[15:8]      = din;
              6'd5: sh_d.id[7:0]       = din;
              6'd6: begin
                sh_d.df             = din[6];
                sh_d.frag_off[12:8] = din[4:0];
              end
              6'd7: sh_d.frag_off[7:0] = din;
              default: ;
            endcase
            if (s.in_eof) begin
              trunc_d = 1'b1;
              state_d = S_IDLE;
            end else if (cnt_q == 6'd9 &&
                         (ver_q != 4'd4 ||
                          sh_q.ihl < 4'd5 ||
                          din != 8'd6)) begin
              skip_d  = 1'b1;
              state_d = S_DRAIN;
            end else if (cnt_q == 6'd19) begin
              cnt_d   = '0;
              state_d = (sh_q.ihl > 4'd5) ?
                        S_IP_OPT : S_TCP_HDR;
            end
          end
        end
        S_IP_OPT: begin
          if (xfer) begin
            if (s.in_eof) begin
              trunc_d = 1'b1;
              state_d = S_IDLE;
            end else if (cnt_q == opt_last) begin
              cnt_d   = '0;
              state_d = S_TCP_HDR;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        S_TCP_HDR: begin
          if (xfer) begin
            cnt_d = cnt_q + 6'd1;
            case (cnt_q)
              6'd12: sh_d.doff = din[7:4];
              6'd13: begin
                sh_d.fin     = din[0];
                sh_d.syn     = din[1];
                sh_d.tcp_rst = din[2];
                sh_d.ack     = din[4];
              end
              6'd14: sh_d.window[15:8] = din;
              6'd15: sh_d.window[7:0]  = din;
              default: ;
            endcase
            if (cnt_q == 6'd15) begin
              state_d = s.in_eof ? S_ISSUE : S_DRAIN;
            end else if (s.in_eof) begin
              trunc_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (xfer && s.in_eof) begin
            if (skip_q) begin
              ntcp_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            state_d = S_IDLE;
          end else if (wcnt_q == TMO_LAST) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (restart) begin
      ver_d    = din[7:4];
      sh_d.ihl = din[3:0];
      skip_d   = 1'b0;
      cnt_d    = 6'd1;
      state_d  = S_IP_HDR;
    end
  end

  assign start_d = (state_d == S_ISSUE);
  assign err_ev  = ntcp_d | trunc_d | tmo_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      ver_q     <= '0;
      skip_q    <= 1'b0;
      sh_q      <= '0;
      fld_q     <= '0;
      start_q   <= 1'b0;
      ntcp_q    <= 1'b0;
      trunc_q   <= 1'b0;
      tmo_q     <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      ver_q   <= ver_d;
      skip_q  <= skip_d;
      sh_q    <= sh_d;
      start_q <= start_d;
      ntcp_q  <= ntcp_d;
      trunc_q <= trunc_d;
      tmo_q   <= tmo_d;
      // Shadow copy reaches the outputs only for a
      // packet that will launch the trees.
      if (start_d) fld_q <= sh_d;
      if (start_d && pkt_cnt_q != '1)
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (err_ev && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign start           = start_q;
  assign non_tcp         = ntcp_q;
  assign err_trunc       = trunc_q;
  assign timeout         = tmo_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign l3_iph_tot_len  = fld_q.tot_len;
  assign l3_iph_ihl      = fld_q.ihl;
  assign l3_iph_tos      = fld_q.tos;
  assign l3_iph_frag_off = fld_q.frag_off;
  assign l3_iph_id       = fld_q.id;
  assign l3_iph_df       = fld_q.df;
  assign l4_tcph_window  = fld_q.window;
  assign l4_tcph_syn     = fld_q.syn;
  assign l4_tcph_fin     = fld_q.fin;
  assign l4_tcph_rst     = fld_q.tcp_rst;
  assign l4_tcph_ack     = fld_q.ack;
  assign l4_tcph_doff    = fld_q.doff;

endmodule

// File: tb/tb_nids_hdr_parser.sv
// Randomized bench for nids_hdr_parser against a
// byte-offset reference model of IPv4/TCP parsing.
module tb_nids_hdr_parser;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done = 1'b0;
  always #5 clk = ~clk;

  nids_hdr_parser_if bus();

  logic        start, non_tcp, err_trunc, timeout;
  logic [15:0] tot_len, id, window;
  logic [3:0]  ihl, doff;
  logic [7:0]  tos;
  logic [12:0] frag;
  logic        df, syn, fin, trst, ack;
  logic [1:0]  pkt_cnt, err_cnt;

  nids_hdr_parser #(.CNT_W(2), .DONE_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .s(bus), .done(done),
    .start(start),
    .l3_iph_tot_len(tot_len), .l3_iph_ihl(ihl),
    .l3_iph_tos(tos), .l3_iph_frag_off(frag),
    .l3_iph_id(id), .l3_iph_df(df),
    .l4_tcph_window(window), .l4_tcph_syn(syn),
    .l4_tcph_fin(fin), .l4_tcph_rst(trst),
    .l4_tcph_ack(ack), .l4_tcph_doff(doff),
    .non_tcp(non_tcp), .err_trunc(err_trunc),
    .timeout(timeout),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int c_st = 0, c_nt = 0, c_tr = 0, c_tm = 0;
  logic [81:0] m_fld = '0;
  int m_pkt = 0;
  int m_err = 0;

  always @(negedge clk) begin
    if (start)     c_st++;
    if (non_tcp)   c_nt++;
    if (err_trunc) c_tr++;
    if (timeout)   c_tm++;
  end

  function automatic logic [81:0] dut_fld();
    return {tot_len, ihl, tos, frag, id, df, window,
            syn, fin, trst, ack, doff};
  endfunction

  function automatic int sat(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  function automatic logic [81:0] ref_fld(
    input logic [7:0] p[$]);
    int b;
    logic [7:0] h0, g6, t12, t13;
    h0  = p[0];
    b   = 4 * int'(h0[3:0]);
    g6  = p[6];
    t12 = p[b+12];
    t13 = p[b+13];
    return {p[2], p[3], h0[3:0], p[1], g6[4:0], p[7],
            p[4], p[5], g6[6], p[b+14], p[b+15],
            t13[1], t13[0], t13[2], t13[4], t12[7:4]};
  endfunction

  // 0 = launch, 1 = non_tcp, 2 = truncated
  function automatic int ref_cls(input logic [7:0] p[$]);
    int n, hl;
    logic [7:0] h0;
    n  = p.size();
    h0 = p[0];
    hl = int'(h0[3:0]);
    if (n <= 10) return 2;
    if (h0[7:4] != 4'd4 || hl < 5 || p[9] != 8'd6)
      return 1;
    if (n < hl * 4 + 16) return 2;
    return 0;
  endfunction

  function automatic bit ref_tmo(input int d);
    return (d == 0) || (d > 10) || (d < 0);
  endfunction

  task automatic upd(input logic [7:0] p[$], input int d);
    int c;
    c = ref_cls(p);
    if (c == 0) begin
      m_pkt++;
      m_fld = ref_fld(p);
      if (ref_tmo(d)) m_err++;
    end else begin
      m_err++;
    end
  endtask

  task automatic mk(output logic [7:0] p[$],
                    input int ver, input int hl,
                    input int pr, input int n);
    p.delete();
    for (int i = 0; i < n; i++)
      p.push_back(8'($urandom));
    p[0] = {4'(ver), 4'(hl)};
    if (n > 9) p[9] = 8'(pr);
  endtask

  task automatic send(input logic [7:0] p[$], input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_data  = p[i];
      bus.in_sof   = (i == 0);
      bus.in_eof   = (i == n - 1) && (n == p.size());
      bus.in_valid = 1'b1;
      g = 0;
      while (!bus.in_ready && g < 64) begin
        @(negedge clk);
        g++;
      end
      if (g >= 64) begin
        n_chk++;
        $display("FAIL send_ready got=0 want=1");
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
  endtask

  task automatic post(input int d, output bit st,
                      output int rh);
    int g;
    st = start;
    rh = 0;
    if (st) begin
      if (bus.in_ready) rh++;
      if (d == 0) begin
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
      end else if (d > 0) begin
        for (int k = 1; k <= d; k++) begin
          @(negedge clk);
          if (bus.in_ready) rh++;
          if (k == d) begin
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
          end
        end
      end
    end
    g = 0;
    while (!bus.in_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    n_chk++;
    if (g >= 60)
      $display("FAIL ready_return got=0 want=1");
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b1;
    bus.in_eof   = 1'b0;
    bus.in_data  = 8'h45;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b1 || start !== 1'b0)
      $display("FAIL rst_ready got=%b/%b want=1/0",
               bus.in_ready, start);
    else n_pass++;
    n_chk++;
    if ({pkt_cnt, err_cnt, non_tcp, err_trunc,
         timeout} !== '0)
      $display("FAIL rst_cnt got=%h want=0",
               {pkt_cnt, err_cnt});
    else n_pass++;
    n_chk++;
    if (dut_fld() !== 82'd0)
      $display("FAIL rst_fld got=%h want=0", dut_fld());
    else n_pass++;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b1 || start !== 1'b0)
      $display("FAIL post_rst got=%b want=1",
               bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_minimal();
    logic [7:0] p[$];
    bit st;
    int rh, s0;
    mk(p, 4, 5, 6, 40);
    p[1] = 8'h10; p[2] = 8'h00; p[3] = 8'h28;
    p[4] = 8'h12; p[5] = 8'h34;
    p[6] = 8'h40; p[7] = 8'h00;
    p[32] = 8'h50; p[33] = 8'h12;
    p[34] = 8'hFA; p[35] = 8'hF0;
    s0 = c_st;
    send(p, 40);
    post(3, st, rh);
    upd(p, 3);
    n_chk++;
    if (st !== 1'b1)
      $display("FAIL min_latency got=%b want=1", st);
    else n_pass++;
    n_chk++;
    if (c_st - s0 != 1)
      $display("FAIL min_starts got=%0d want=1", c_st - s0);
    else n_pass++;
    n_chk++;
    if (rh != 0)
      $display("FAIL min_ready got=%0d want=0", rh);
    else n_pass++;
    n_chk++;
    if ({df, frag, doff, syn, ack, fin, trst, window} !==
        {1'b1, 13'd0, 4'd5, 4'b1100, 16'hFAF0})
      $display("FAIL min_tcp got=%b %h %h %h", df, frag,
               doff, window);
    else n_pass++;
    n_chk++;
    if (dut_fld() !== m_fld)
      $display("FAIL min_fld got=%h want=%h",
               dut_fld(), m_fld);
    else n_pass++;
    n_chk++;
    if (pkt_cnt !== 2'd1)
      $display("FAIL min_pkt got=%0d want=1", pkt_cnt);
    else n_pass++;
  endtask

  task automatic test_options();
    logic [7:0] p[$];
    bit st;
    int rh, s0;
    mk(p, 4, 6, 6, 60);
    for (int i = 20; i < 24; i++) p[i] = 8'hAA;
    p[36] = 8'h50;
    p[37] = 8'h01;
    s0 = c_st;
    send(p, 60);
    post(2, st, rh);
    upd(p, 2);
    n_chk++;
    if (c_st - s0 != 1)
      $display("FAIL opt_starts got=%0d want=1", c_st - s0);
    else n_pass++;
    n_chk++;
    if (fin !== 1'b1 || doff !== 4'd5)
      $display("FAIL opt_tcp got=%b/%h want=1/5", fin, doff);
    else n_pass++;
    n_chk++;
    if (dut_fld() !== m_fld)
      $display("FAIL opt_fld got=%h want=%h",
               dut_fld(), m_fld);
    else n_pass++;
  endtask

  task automatic test_udp();
    logic [7:0] p[$];
    bit st;
    int rh, s0;
    bit nt;
    mk(p, 4, 5, 17, 28);
    s0 = c_st;
    send(p, 28);
    nt = non_tcp;
    post(2, st, rh);
    upd(p, 2);
    n_chk++;
    if (nt !== 1'b1)
      $display("FAIL udp_pulse got=%b want=1", nt);
    else n_pass++;
    n_chk++;
    if (c_st - s0 != 0)
      $display("FAIL udp_start got=%0d want=0", c_st - s0);
    else n_pass++;
    n_chk++;
    if (dut_fld() !== m_fld)
      $display("FAIL udp_fld got=%h want=%h",
               dut_fld(), m_fld);
    else n_pass++;
    n_chk++;
    if (err_cnt !== 2'(sat(m_err)))
      $display("FAIL udp_err got=%0d want=%0d",
               err_cnt, sat(m_err));
    else n_pass++;
  endtask

  task automatic test_trunc();
    logic [7:0] p[$];
    bit st, tr;
    int rh, s0;
    mk(p, 4, 5, 6, 16);
    s0 = c_st;
    send(p, 16);
    tr = err_trunc;
    post(2, st, rh);
    upd(p, 2);
    n_chk++;
    if (tr !== 1'b1 || c_st != s0)
      $display("FAIL trunc_pulse got=%b/%0d want=1/0",
               tr, c_st - s0);
    else n_pass++;
    n_chk++;
    if (bus.in_ready !== 1'b1 || dut_fld() !== m_fld)
      $display("FAIL trunc_idle got=%b fld=%h want=%h",
               bus.in_ready, dut_fld(), m_fld);
    else n_pass++;
    mk(p, 4, 5, 6, 44);
    s0 = c_st;
    send(p, 44);
    post(1, st, rh);
    upd(p, 1);
    n_chk++;
    if (c_st - s0 != 1 || dut_fld() !== m_fld)
      $display("FAIL trunc_next got=%h want=%h",
               dut_fld(), m_fld);
    else n_pass++;
  endtask

  task automatic test_sof_abort();
    logic [7:0] a[$];
    logic [7:0] b[$];
    bit st;
    int rh, s0, t0;
    mk(a, 4, 5, 6, 40);
    mk(b, 4, 5, 6, 40);
    s0 = c_st;
    t0 = c_tr;
    send(a, 25);
    send(b, 40);
    post(4, st, rh);
    m_err++;
    upd(b, 4);
    n_chk++;
    if (c_tr - t0 != 1)
      $display("FAIL abort_trunc got=%0d want=1", c_tr - t0);
    else n_pass++;
    n_chk++;
    if (c_st - s0 != 1)
      $display("FAIL abort_start got=%0d want=1", c_st - s0);
    else n_pass++;
    n_chk++;
    if (dut_fld() !== m_fld)
      $display("FAIL abort_fld got=%h want=%h",
               dut_fld(), m_fld);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] p[$];
    int cnt;
    bit st;
    for (int r = 0; r < 4; r++) begin
      mk(p, 4, 5, 6, 40);
      send(p, 40);
      st = start;
      @(negedge clk);
      cnt = 0;
      while (!timeout && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      upd(p, -1);
      n_chk++;
      if (st !== 1'b1 || cnt != 10)
        $display("FAIL tmo_cycles got=%0d want=10", cnt);
      else n_pass++;
      n_chk++;
      if (bus.in_ready !== 1'b1)
        $display("FAIL tmo_ready got=%b want=1",
                 bus.in_ready);
      else n_pass++;
      repeat (2) @(negedge clk);
    end
    n_chk++;
    if (err_cnt !== 2'd3 || pkt_cnt !== 2'(sat(m_pkt)))
      $display("FAIL tmo_sat got=%0d/%0d want=3/%0d",
               err_cnt, pkt_cnt, sat(m_pkt));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    int ver, hl, pr, n, full, d, c;
    int s0, n0, t0, m0, rh;
    bit bad, st, etm;
    for (int it = 0; it < 30; it++) begin
      ver = ($urandom_range(0, 9) == 0) ? 5 : 4;
      hl  = ($urandom_range(0, 9) < 2) ?
            $urandom_range(2, 4) : $urandom_range(5, 8);
      pr  = ($urandom_range(0, 7) == 0) ? 17 : 6;
      bad = (ver != 4) || (hl < 5) || (pr != 6);
      full = hl * 4 + 16;
      if (bad)
        n = $urandom_range(11, 40);
      else if ($urandom_range(0, 3) == 0)
        n = $urandom_range(1, full - 1);
      else
        n = full + $urandom_range(0, 8);
      d = $urandom_range(0, 12);
      mk(p, ver, hl, pr, n);
      if ($urandom_range(0, 2) == 0) begin
        bus.in_data  = 8'($urandom);
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      s0 = c_st; n0 = c_nt; t0 = c_tr; m0 = c_tm;
      c = ref_cls(p);
      etm = (c == 0) && ref_tmo(d);
      send(p, n);
      post(d, st, rh);
      upd(p, d);
      n_chk++;
      if (c_st - s0 != int'(c == 0))
        $display("FAIL rnd%0d_start got=%0d want=%0d",
                 it, c_st - s0, int'(c == 0));
      else n_pass++;
      n_chk++;
      if (c_nt - n0 != int'(c == 1))
        $display("FAIL rnd%0d_nontcp got=%0d want=%0d",
                 it, c_nt - n0, int'(c == 1));
      else n_pass++;
      n_chk++;
      if (c_tr - t0 != int'(c == 2))
        $display("FAIL rnd%0d_trunc got=%0d want=%0d",
                 it, c_tr - t0, int'(c == 2));
      else n_pass++;
      n_chk++;
      if (c_tm - m0 != int'(etm))
        $display("FAIL rnd%0d_tmo got=%0d want=%0d",
                 it, c_tm - m0, int'(etm));
      else n_pass++;
      n_chk++;
      if (dut_fld() !== m_fld)
        $display("FAIL rnd%0d_fld got=%h want=%h",
                 it, dut_fld(), m_fld);
      else n_pass++;
      n_chk++;
      if (pkt_cnt !== 2'(sat(m_pkt)) ||
          err_cnt !== 2'(sat(m_err)))
        $display("FAIL rnd%0d_cnt got=%0d/%0d want=%0d/%0d",
                 it, pkt_cnt, err_cnt,
                 sat(m_pkt), sat(m_err));
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_minimal();
    test_options();
    test_udp();
    test_trunc();
    test_sof_abort();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
